// File: rtl/vout_spipoti_multi.sv
// vout_spipoti_multi: multi-channel SPI digital-potentiometer driver.
// Serialises CHANNELS packed WIDTH-bit setpoints as {channel index, data}
// frames, MSB first, SPI mode 0, SCLK half-period of DIVIDER clk cycles.
// Optional feature macro: VOUT_SPIPOTI_MULTI_SKIP_UNCHANGED_EN
//   defined   -> only channels whose setpoint changed are retransmitted
//   undefined -> continuous round-robin refresh of all channels
module vout_spipoti_multi #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 4,
   parameter int ADDR_BITS = 2,
   parameter int DIVIDER   = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CHANNELS*WIDTH-1:0]  value,
   output logic                       MOSI,
   output logic                       SCLK,
   output logic                       CS,
   output logic                       busy
);

   localparam int FRAME = ADDR_BITS + WIDTH;
   localparam int DIV_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam int BIT_W = $clog2(FRAME);

   localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(DIVIDER - 1);
   localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(FRAME - 1);
   localparam logic [ADDR_BITS-1:0] CH_LAST  = ADDR_BITS'(CHANNELS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      GAP
   } state_t;

   state_t               state;
   logic [ADDR_BITS-1:0] ptr;        // round-robin start point
   logic [ADDR_BITS-1:0] sent_ch;    // channel of the frame in flight
   logic [FRAME-2:0]     shift_reg;  // bits still to go after the one on MOSI
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;

   logic [ADDR_BITS-1:0] sel_ch;
   logic                 sel_valid;
   logic [WIDTH-1:0]     sel_data;
   logic [FRAME-1:0]     frame_word;

`ifdef VOUT_SPIPOTI_MULTI_SKIP_UNCHANGED_EN
   logic [CHANNELS-1:0]  pending;
   logic [WIDTH-1:0]     shadow [CHANNELS];

   // Pick the first pending channel at or after the pointer, wrapping.
   always_comb begin
      int k;
      // NOTE: every output of a combinational block gets a default up front,
      // otherwise paths that skip an assignment infer latches.
      sel_ch    = ptr;
      sel_valid = 1'b0;
      k         = 0;
      // Walk backwards so the closest candidate to the pointer wins.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         k = int'(ptr) + i;
         if (k >= CHANNELS) k = k - CHANNELS;
         if (pending[k]) begin
            sel_ch    = ADDR_BITS'(k);
            sel_valid = 1'b1;
         end
      end
   end

   // Track which setpoints differ from what the device last received.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '1;
         // NOTE: the shadow array is a handful of flops, not a RAM, so it is
         // safe to clear it in reset; that forces one send per channel.
         for (int n = 0; n < CHANNELS; n++) shadow[n] <= '0;
      end else begin
         for (int n = 0; n < CHANNELS; n++) begin
            // A change on the latch cycle is caught next cycle against the
            // new shadow, so the old value goes out and pending re-arms.
            if (state == IDLE && sel_valid && sel_ch == ADDR_BITS'(n)) begin
               shadow[n]  <= value[n*WIDTH +: WIDTH];
               pending[n] <= 1'b0;
            end else if (value[n*WIDTH +: WIDTH] != shadow[n]) begin
               pending[n] <= 1'b1;
            end
         end
      end
   end
`else
   // Continuous refresh: always send the pointer channel.
   always_comb begin
      sel_ch    = ptr;
      sel_valid = 1'b1;
   end
`endif

   // Slice of the selected channel and the frame it produces.
   always_comb begin
      sel_data   = value[int'(sel_ch)*WIDTH +: WIDTH];
      frame_word = {sel_ch, sel_data};
   end

   // Frame sequencer; every bus output is a register.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state is written with <= only, so every register
         // in this block sees the pre-edge values regardless of statement order.
         state     <= IDLE;
         ptr       <= '0;
         sent_ch   <= '0;
         shift_reg <= '0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         CS        <= 1'b1;
         SCLK      <= 1'b0;
         MOSI      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  MOSI      <= frame_word[FRAME-1];
                  shift_reg <= frame_word[FRAME-2:0];
                  sent_ch   <= sel_ch;
                  CS        <= 1'b0;
                  SCLK      <= 1'b0;
                  busy      <= 1'b1;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  SCLK    <= 1'b1;
                  state   <= HIGH;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            HIGH: begin
               if (div_cnt == DIV_LAST) begin
                  // Falling edge: present the next bit while SCLK is low.
                  div_cnt           <= '0;
                  SCLK              <= 1'b0;
                  {MOSI, shift_reg} <= {shift_reg, 1'b0};
                  state             <= LOW;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            LOW: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     CS    <= 1'b1;
                     MOSI  <= 1'b0;
                     state <= GAP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     SCLK    <= 1'b1;
                     state   <= HIGH;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            GAP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  busy    <= 1'b0;
                  ptr     <= (sent_ch == CH_LAST) ? '0 : sent_ch + 1'b1;
                  state   <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vout_spipoti_multi.sv
// Directed testbench for vout_spipoti_multi. Instance A uses the default
// parameters; instance B uses DIVIDER=1, WIDTH=10, CHANNELS=6, ADDR_BITS=3.
// Expectations follow VOUT_SPIPOTI_MULTI_SKIP_UNCHANGED_EN when defined.
module tb_vout_spipoti_multi;

   localparam int W_A = 8,  C_A = 4, AB_A = 2, D_A = 2;
   localparam int W_B = 10, C_B = 6, AB_B = 3, D_B = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset_a, reset_b;
   logic [C_A*W_A-1:0]   value_a;
   logic [C_B*W_B-1:0]   value_b;
   logic                 mosi_a, sclk_a, cs_a, busy_a;
   logic                 mosi_b, sclk_b, cs_b, busy_b;

   // Bus observed by the capture task.
   bit   sel_b = 1'b0;
   logic cs_m, sclk_m, mosi_m, busy_m;
   assign cs_m   = sel_b ? cs_b   : cs_a;
   assign sclk_m = sel_b ? sclk_b : sclk_a;
   assign mosi_m = sel_b ? mosi_b : mosi_a;
   assign busy_m = sel_b ? busy_b : busy_a;

   int checks = 0;
   int errors = 0;

   vout_spipoti_multi #(.WIDTH(W_A), .CHANNELS(C_A), .ADDR_BITS(AB_A), .DIVIDER(D_A)) dut_a (
      .clk(clk), .reset(reset_a), .value(value_a),
      .MOSI(mosi_a), .SCLK(sclk_a), .CS(cs_a), .busy(busy_a)
   );

   vout_spipoti_multi #(.WIDTH(W_B), .CHANNELS(C_B), .ADDR_BITS(AB_B), .DIVIDER(D_B)) dut_b (
      .clk(clk), .reset(reset_b), .value(value_b),
      .MOSI(mosi_b), .SCLK(sclk_b), .CS(cs_b), .busy(busy_b)
   );

   // Wait for CS low, then record one frame sampled on falling clk edges.
   // hi_len counts CS-high samples seen before the frame started.
   // Optionally rewrites channel poke_addr of value_a once its address is seen.
   task automatic capture(input int nbits, input int abits, input int poke_addr,
                          input logic [W_A-1:0] poke_val,
                          output logic [15:0] word, output int hi_len,
                          output int cs_len, output int edges, output bit clean,
                          output bit busy_ok, output bit poked, output bit got);
      int   nb;
      logic prev_sclk, prev_mosi;
      word = '0; hi_len = 0; cs_len = 0; edges = 0;
      clean = 1'b1; busy_ok = 1'b1; poked = 1'b0; got = 1'b0; nb = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cs_m === 1'b0) begin
            got = 1'b1;
            break;
         end
         hi_len++;
      end
      if (!got) return;
      cs_len    = 1;
      prev_sclk = sclk_m;
      prev_mosi = mosi_m;
      if (busy_m !== 1'b1) busy_ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cs_m !== 1'b0) break;
         cs_len++;
         if (busy_m !== 1'b1) busy_ok = 1'b0;
         if (sclk_m !== prev_sclk) edges++;
         if (mosi_m !== prev_mosi && sclk_m !== 1'b0) clean = 1'b0;
         if (sclk_m === 1'b1 && prev_sclk === 1'b0) begin
            word = {word[14:0], mosi_m};
            nb++;
            if (poke_addr >= 0 && !poked && nb == abits && int'(word) == poke_addr) begin
               value_a[poke_addr*W_A +: W_A] = poke_val;
               poked = 1'b1;
            end
         end
         prev_sclk = sclk_m;
         prev_mosi = mosi_m;
      end
      if (nb != nbits) clean = 1'b0;
   endtask

   task automatic test_reset();
      reset_a = 1'b1;
      reset_b = 1'b1;
      value_a = 32'h0403_0201;
      value_b = {10'h30C, 10'h0F0, 10'h3FF, 10'h001, 10'h2AA, 10'h155};
      repeat (3) @(negedge clk);
      checks++; if (cs_a   !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", cs_a); end
      checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk_a); end
      checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
   endtask

   // Startup: every channel sent once in order 0..3.
   task automatic test_rotation();
      logic [15:0] word, exp;
      int hi, len, edges;
      bit clean, bok, poked, got, idle_ok;
      sel_b   = 1'b0;
      reset_a = 1'b0;
      for (int f = 0; f < 4; f++) begin
         capture(AB_A + W_A, AB_A, -1, '0, word, hi, len, edges, clean, bok, poked, got);
         exp = 16'((f << 8) | (f + 1));
         checks++; if (!got) begin errors++; $display("FAIL rot%0d_start: CS never fell", f); end
         checks++; if (word !== exp) begin errors++; $display("FAIL rot%0d_word: got %0h expected %0h", f, word, exp); end
         checks++; if (len !== 42) begin errors++; $display("FAIL rot%0d_cs_low: got %0d expected 42", f, len); end
         checks++; if (edges !== 20) begin errors++; $display("FAIL rot%0d_edges: got %0d expected 20", f, edges); end
         checks++; if (!clean) begin errors++; $display("FAIL rot%0d_mosi_timing: got 0 expected 1", f); end
         checks++; if (!bok) begin errors++; $display("FAIL rot%0d_busy: got 0 expected 1", f); end
         if (f == 0) begin
            checks++; if (hi !== 0) begin errors++; $display("FAIL rot0_latency: got %0d expected 0", hi); end
         end else begin
            checks++; if (hi + 1 !== D_A + 1) begin errors++; $display("FAIL rot%0d_gap: got %0d expected %0d", f, hi + 1, D_A + 1); end
         end
      end
`ifdef VOUT_SPIPOTI_MULTI_SKIP_UNCHANGED_EN
      idle_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cs_a !== 1'b1) idle_ok = 1'b0;
      end
      checks++; if (!idle_ok) begin errors++; $display("FAIL rot_idle: got 0 expected 1"); end
`else
      idle_ok = 1'b1;
      capture(AB_A + W_A, AB_A, -1, '0, word, hi, len, edges, clean, bok, poked, got);
      checks++; if (word !== 16'h001) begin errors++; $display("FAIL rot4_word: got %0h expected 1", word); end
      checks++; if (hi + 1 !== D_A + 1) begin errors++; $display("FAIL rot4_gap: got %0d expected %0d", hi + 1, D_A + 1); end
`endif
   endtask

   // Channel 2 -> 0xA5 shows up as frame 10_10100101.
   task automatic test_change();
      logic [15:0] word;
      int hi, len, edges, nframes;
      bit clean, bok, poked, got, found, idle_ok;
      value_a[23:16] = 8'hA5;
      found = 1'b0; nframes = 0;
      for (int f = 0; f < 4 && !found; f++) begin
         capture(AB_A + W_A, AB_A, -1, '0, word, hi, len, edges, clean, bok, poked, got);
         nframes++;
         if (got && word[9:8] == 2'd2) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL chg_found: got 0 expected 1"); end
      checks++; if (word !== 16'h2A5) begin errors++; $display("FAIL chg_word: got %0h expected 2a5", word); end
      checks++; if (len !== 42) begin errors++; $display("FAIL chg_cs_low: got %0d expected 42", len); end
      checks++; if (edges !== 20) begin errors++; $display("FAIL chg_edges: got %0d expected 20", edges); end
`ifdef VOUT_SPIPOTI_MULTI_SKIP_UNCHANGED_EN
      checks++; if (nframes !== 1) begin errors++; $display("FAIL chg_frames: got %0d expected 1", nframes); end
      idle_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cs_a !== 1'b1) idle_ok = 1'b0;
      end
      checks++; if (!idle_ok) begin errors++; $display("FAIL chg_idle: got 0 expected 1"); end
`else
      idle_ok = 1'b1;
      checks++; if (nframes !== 2) begin errors++; $display("FAIL chg_frames: got %0d expected 2", nframes); end
`endif
   endtask

   // Channel 1 changes mid-frame: old data goes out, new data follows.
   task automatic test_mid_frame_change();
      logic [15:0] word, w1, w2;
      int hi, len, edges, between;
      bit clean, bok, poked, got, poked_any, first_seen, second_seen;
      value_a[15:8] = 8'h33;
      w1 = '0; w2 = '0; between = 0;
      poked_any = 1'b0; first_seen = 1'b0; second_seen = 1'b0;
      for (int f = 0; f < 8 && !second_seen; f++) begin
         capture(AB_A + W_A, AB_A, poked_any ? -1 : 1, 8'h55, word, hi, len, edges, clean, bok, poked, got);
         if (poked) poked_any = 1'b1;
         if (got && word[9:8] == 2'd1) begin
            if (!first_seen) begin first_seen = 1'b1; w1 = word; end
            else begin second_seen = 1'b1; w2 = word; end
         end else if (first_seen) begin
            between++;
         end
      end
      checks++; if (!poked_any) begin errors++; $display("FAIL mid_poked: got 0 expected 1"); end
      checks++; if (w1 !== 16'h133) begin errors++; $display("FAIL mid_old_word: got %0h expected 133", w1); end
      checks++; if (w2 !== 16'h155) begin errors++; $display("FAIL mid_new_word: got %0h expected 155", w2); end
`ifdef VOUT_SPIPOTI_MULTI_SKIP_UNCHANGED_EN
      checks++; if (between !== 0) begin errors++; $display("FAIL mid_between: got %0d expected 0", between); end
`else
      checks++; if (between !== 3) begin errors++; $display("FAIL mid_between: got %0d expected 3", between); end
`endif
   endtask

   // One-cycle reset inside a frame: bus idles next cycle, resend from 0.
   task automatic test_reset_mid_frame();
      logic [15:0] word, exp;
      logic [7:0]  data [4];
      int hi, len, edges;
      bit clean, bok, poked, got, seen_high;
      data[0] = 8'h01; data[1] = 8'h55; data[2] = 8'hA5; data[3] = 8'h77;
      value_a[31:24] = 8'h77;
      got = 1'b0; seen_high = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cs_a === 1'b1) seen_high = 1'b1;
         else if (seen_high && cs_a === 1'b0) begin got = 1'b1; break; end
      end
      checks++; if (!got) begin errors++; $display("FAIL rmid_start: CS never fell"); end
      repeat (10) @(negedge clk);
      checks++; if (cs_a !== 1'b0) begin errors++; $display("FAIL rmid_in_frame: got %b expected 0", cs_a); end
      reset_a = 1'b1;
      @(negedge clk);
      checks++; if (cs_a   !== 1'b1) begin errors++; $display("FAIL rmid_cs: got %b expected 1", cs_a); end
      checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL rmid_sclk: got %b expected 0", sclk_a); end
      checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL rmid_mosi: got %b expected 0", mosi_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy_a); end
      reset_a = 1'b0;
      for (int f = 0; f < 4; f++) begin
         capture(AB_A + W_A, AB_A, -1, '0, word, hi, len, edges, clean, bok, poked, got);
         exp = 16'((f << 8) | data[f]);
         checks++; if (word !== exp) begin errors++; $display("FAIL rmid%0d_word: got %0h expected %0h", f, word, exp); end
         if (f == 0) begin
            checks++; if (hi !== 0) begin errors++; $display("FAIL rmid0_latency: got %0d expected 0", hi); end
         end
      end
   endtask

   // Instance B: 13-bit frames, CS low 27 clk, MOSI moves only with SCLK low.
   task automatic test_div1();
      logic [15:0] word, exp;
      int hi, len, edges;
      bit clean, bok, poked, got;
      sel_b   = 1'b1;
      reset_b = 1'b0;
      for (int f = 0; f < C_B; f++) begin
         capture(AB_B + W_B, AB_B, -1, '0, word, hi, len, edges, clean, bok, poked, got);
         exp = 16'((f << W_B) | int'(value_b[f*W_B +: W_B]));
         checks++; if (word !== exp) begin errors++; $display("FAIL div1_%0d_word: got %0h expected %0h", f, word, exp); end
         checks++; if (len !== 27) begin errors++; $display("FAIL div1_%0d_cs_low: got %0d expected 27", f, len); end
         checks++; if (edges !== 26) begin errors++; $display("FAIL div1_%0d_edges: got %0d expected 26", f, edges); end
         checks++; if (!clean) begin errors++; $display("FAIL div1_%0d_mosi_timing: got 0 expected 1", f); end
         if (f > 0) begin
            checks++; if (hi + 1 !== D_B + 1) begin errors++; $display("FAIL div1_%0d_gap: got %0d expected %0d", f, hi + 1, D_B + 1); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_change();
      test_mid_frame_change();
      test_reset_mid_frame();
      test_div1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
